// File: rtl/fsm_serialtx.sv
// Serial frame transmitter: start bit, LSB-first data, optional odd parity, stop bit(s).
// A one-entry holding buffer lets consecutive frames leave with no idle gap.
module fsm_serialtx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_byte,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned MAXC = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic                 buf_full_q, buf_full_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 pull;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    out_d      = out_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    pull       = 1'b0;

    // out_d is the line value for the state being entered, so out stays a pure flop
    unique case (state_q)
      S_IDLE: begin
        if (buf_full_q) pull = 1'b1;
        else            out_d = 1'b1;
      end
      S_START: begin
        state_d = S_DATA;
        out_d   = shift_q[0];
        par_d   = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          if (PARITY_EN != 0) begin
            state_d = S_PARITY;
            out_d   = ~par_q;
          end else begin
            state_d = S_STOP;
            out_d   = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          out_d   = shift_q[0];
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
        out_d   = 1'b1;
        cnt_d   = '0;
      end
      S_STOP: begin
        if (cnt_q == STOP_LAST) begin
          if (buf_full_q) begin
            pull = 1'b1;
          end else begin
            state_d = S_IDLE;
            out_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
      end
    endcase

    // Pull needs a full buffer and accept an empty one, so they are exclusive
    if (pull) begin
      state_d    = S_START;
      out_d      = 1'b0;
      shift_d    = buf_data_q;
      buf_full_d = 1'b0;
      cnt_d      = '0;
    end else if (in_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_data_d = in_byte;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      buf_data_q <= '0;
      buf_full_q <= 1'b0;
      par_q      <= 1'b0;
      out_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      buf_data_q <= buf_data_d;
      buf_full_q <= buf_full_d;
      par_q      <= par_d;
      out_q      <= out_d;
    end
  end

  assign in_ready = !buf_full_q;
  assign out      = out_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_STOP) && (cnt_q == STOP_LAST);

endmodule
